// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store sequencer onto a word memory port.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two beats.
module load_store_unit #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [2:0]            mem_op_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    RESP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_ONE = 1;

  state_t state;
  state_t state_nxt;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q;
  logic [63:0]           buf_q;

  logic        accept;
  logic        req_illegal;
  logic        req_bad;
  logic [7:0]  base;
  logic [7:0]  mask8;
  logic [63:0] sh64;
  logic [63:0] buf_nxt;
  logic [31:0] raw;
  logic [31:0] ld_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  assign accept      = (state == IDLE) && req_valid;
  assign mem_op_read = 3'b010;

  // Classify the incoming request as illegal (or misaligned when unsplit)
  always_comb begin
    req_illegal = 1'b0;
    if (req_we)
      req_illegal = (req_funct3 >= 3'b011);
    else
      req_illegal = (req_funct3 == 3'b011) ||
                    (req_funct3[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_EN
  logic [2:0] size;
  logic       cross;

  assign req_bad = req_illegal;

  // Access size in bytes and whether it spills into the next word
  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    cross = ({1'b0, off_q} + size) > 3'd4;
  end
`else
  logic req_misal;

  assign req_misal =
    ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_bad = req_illegal || req_misal;
`endif

  // Byte lane mask and lane-shifted store data over two words
  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    mask8 = base << off_q;
    sh64  = {32'b0, wdata_q} << {off_q, 3'b000};
  end

  // Load buffer with the word arriving this cycle merged in
  always_comb begin
    if (state == SECOND)
      buf_nxt = {mem_rdata, buf_q[31:0]};
    else
      buf_nxt = {buf_q[63:32], mem_rdata};
    raw = 32'(buf_nxt >> {off_q, 3'b000});
  end

  // Truncate and extend the aligned load data
  always_comb begin
    ld_data = '0;
    case (f3_q)
      3'b000:  ld_data = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ld_data = {{16{raw[15]}}, raw[15:0]};
      3'b010:  ld_data = raw;
      3'b100:  ld_data = {24'b0, raw[7:0]};
      3'b101:  ld_data = {16'b0, raw[15:0]};
      default: ld_data = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (req_valid)
          state_nxt = req_bad ? RESP : FIRST;
      FIRST:
`ifdef LSU_MISALIGN_EN
        state_nxt = cross ? SECOND : RESP;
`else
        state_nxt = RESP;
`endif
      SECOND:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port and handshake decode; reset blocks an in-flight write
  always_comb begin
    req_ready = (state == IDLE);
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      FIRST: begin
        mem_we    = we_q && !rst;
        mem_be    = mask8[3:0];
        mem_addr  = waddr_q;
        mem_wdata = sh64[31:0];
      end
      SECOND: begin
        mem_we    = we_q && !rst;
        mem_be    = mask8[7:4];
        mem_addr  = waddr_q + WORD_ONE;
        mem_wdata = sh64[63:32];
      end
      default: ;
    endcase
  end

  // Latch the request on accept, then collect load words
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      off_q   <= req_addr[1:0];
      waddr_q <= req_addr[ADDR_WIDTH+1:2];
      wdata_q <= req_wdata;
    end else if (!we_q &&
                 (state == FIRST || state == SECOND)) begin
      buf_q <= buf_nxt;
    end
  end

  // Registered response, raised on entry to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state_nxt == RESP);
      if (state_nxt == RESP) begin
        resp_err <= (state == IDLE);
        if (state == IDLE || we_q)
          resp_rdata <= '0;
        else
          resp_rdata <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus random load/store checks
// against a byte-array memory model.
module tb_load_store_unit;

  localparam int AW = 15;
  localparam int NW = 1 << AW;
  localparam int NB = NW * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [2:0]    mem_op_read;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] ram [NW];
  logic [7:0]  ref_mem [NB];

  logic          cap_we [1:3];
  logic [3:0]    cap_be [1:3];
  logic [AW-1:0] cap_addr [1:3];
  logic [31:0]   cap_wd [1:3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  load_store_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_we(mem_we),
    .mem_be(mem_be),
    .mem_op_read(mem_op_read),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic int f_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit f_bad(input bit we,
                               input logic [2:0] f3,
                               input logic [31:0] a);
    bit ill;
    if (we) ill = (f3 >= 3'd3);
    else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (ill) return 1'b1;
`ifndef LSU_MISALIGN_EN
    if ((int'(a[1:0]) % f_size(f3)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int bidx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] v;
    int sz;
    v  = '0;
    sz = f_size(f3);
    for (int i = 0; i < sz; i++)
      v = v | (32'(ref_mem[bidx(a, i)]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1])
      v = v | ~((32'h1 << (8 * sz)) - 32'h1);
    return v;
  endfunction

  function automatic logic [31:0] f_word(input int w);
    int b;
    b = (w % NW) * 4;
    return {ref_mem[b+3], ref_mem[b+2],
            ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    ram[w] = v;
    for (int i = 0; i < 4; i++)
      ref_mem[w*4+i] = v[8*i +: 8];
  endtask

  task automatic do_req(input bit we,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd_o,
                        output logic err_o,
                        output int lat_o);
    bit bad, seen, we_hi;
    int sz, nacc, exp_lat, w0;
    logic [3:0] be1, be2;
    logic [31:0] exp_rd;
    sz  = f_size(f3);
    bad = f_bad(we, f3, a);
    be1 = '0;
    be2 = '0;
    for (int i = 0; i < sz; i++) begin
      int ln;
      ln = int'(a[1:0]) + i;
      if (ln < 4) be1[ln] = 1'b1;
      else        be2[ln-4] = 1'b1;
    end
    nacc    = (be2 != 4'b0) ? 2 : 1;
    exp_lat = bad ? 1 : nacc + 1;
    exp_rd  = (bad || we) ? 32'h0 : f_load(f3, a);
    w0      = int'(a[16:2]);
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    seen  = 1'b0;
    we_hi = 1'b0;
    lat_o = 0;
    rd_o  = '0;
    err_o = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      if (c <= 3) begin
        cap_we[c]   = mem_we;
        cap_be[c]   = mem_be;
        cap_addr[c] = mem_addr;
        cap_wd[c]   = mem_wdata;
      end
      if (mem_we) we_hi = 1'b1;
      if (resp_valid) begin
        seen  = 1'b1;
        lat_o = c;
        rd_o  = resp_rdata;
        err_o = resp_err;
      end else begin
        @(negedge clk);
      end
    end
    chk("resp_seen", 32'(seen), 1);
    chk("latency", lat_o, exp_lat);
    chk("resp_err", 32'(err_o), 32'(bad));
    chk("resp_rdata", rd_o, exp_rd);
    if (bad) begin
      chk("err_no_we", 32'(we_hi), 0);
    end else begin
      for (int c = 1; c <= nacc; c++) begin
        chk("mem_addr", 32'(cap_addr[c]), (w0 + c - 1) % NW);
        chk("mem_be", 32'(cap_be[c]), 32'(c == 1 ? be1 : be2));
        chk("mem_we", 32'(cap_we[c]), 32'(we));
      end
    end
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 0);
    if (we && !bad) begin
      for (int i = 0; i < sz; i++)
        ref_mem[bidx(a, i)] = wd[8*i +: 8];
      chk("ram_w0", ram[w0], f_word(w0));
      if (nacc == 2)
        chk("ram_w1", ram[(w0+1) % NW], f_word(w0 + 1));
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    for (int w = 0; w < NW; w++) set_word(w, 32'h0);
    for (int w = 0; w < 5; w++) set_word(w, $urandom);
    for (int w = 64; w < 73; w++) set_word(w, $urandom);
    for (int w = NW - 4; w < NW; w++) set_word(w, $urandom);

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rv", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_opread", 32'(mem_op_read), 32'h2);
    rst = 1'b0;

    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, er, lat);
    chk("sw_addr", 32'(cap_addr[1]), 32'h40);
    chk("sw_be", 32'(cap_be[1]), 32'hF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
    chk("lw_val", rd, 32'hDEADBEEF);
    chk("lw_lat", lat, 2);

    do_req(1'b1, 3'b000, 32'h103, 32'h80, rd, er, lat);
    chk("sb_be", 32'(cap_be[1]), 32'h8);
    chk("sb_wdata", cap_wd[1], 32'h80000000);
    do_req(1'b0, 3'b000, 32'h103, 32'h0, rd, er, lat);
    chk("lb_val", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, rd, er, lat);
    chk("lbu_val", rd, 32'h00000080);

    do_req(1'b1, 3'b001, 32'h107, 32'hA55A, rd, er, lat);
`ifdef LSU_MISALIGN_EN
    chk("sh_a1", 32'(cap_addr[1]), 32'h41);
    chk("sh_be1", 32'(cap_be[1]), 32'h8);
    chk("sh_b1", 32'(cap_wd[1][31:24]), 32'h5A);
    chk("sh_a2", 32'(cap_addr[2]), 32'h42);
    chk("sh_be2", 32'(cap_be[2]), 32'h1);
    chk("sh_b2", 32'(cap_wd[2][7:0]), 32'hA5);
    do_req(1'b0, 3'b101, 32'h107, 32'h0, rd, er, lat);
    chk("lhu_val", rd, 32'h0000A55A);
    chk("lhu_lat", lat, 3);
    do_req(1'b0, 3'b010, 32'h1FFFE, 32'h0, rd, er, lat);
    chk("wrap_a2", 32'(cap_addr[2]), 32'h0);
`else
    chk("sh_mis_err", 32'(er), 1);
    chk("sh_mis_lat", lat, 1);
    do_req(1'b0, 3'b010, 32'h1FFFE, 32'h0, rd, er, lat);
    chk("lw_mis_err", 32'(er), 1);
`endif

    do_req(1'b0, 3'b011, 32'h104, 32'h0, rd, er, lat);
    chk("ill_err", 32'(er), 1);
    chk("ill_rdata", rd, 0);

`ifdef LSU_MISALIGN_EN
    set_word(32'h200, 32'hAAAAAAAA);
    set_word(32'h201, 32'h55555555);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h802;
    req_wdata  = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rs_first_we", 32'(mem_we), 1);
    @(posedge clk);
    @(negedge clk);
    chk("rs_second_a", 32'(mem_addr), 32'h201);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rs_no_resp", 32'(resp_valid), 0);
    chk("rs_ready", 32'(req_ready), 1);
    rst = 1'b0;
    ref_mem[32'h802] = 8'h44;
    ref_mem[32'h803] = 8'h33;
    chk("rs_w0", ram[32'h200], f_word(32'h200));
    chk("rs_w1", ram[32'h201], 32'h55555555);
    @(negedge clk);
    chk("rs_no_resp2", 32'(resp_valid), 0);
`else
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'hC00;
    req_wdata  = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rs_no_resp", 32'(resp_valid), 0);
    chk("rs_ready", 32'(req_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_no_resp2", 32'(resp_valid), 0);
`endif

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 2);
      if (r == 0)      a = 32'h100 + $urandom_range(0, 31);
      else if (r == 1) a = 32'h1FFF0 + $urandom_range(0, 15);
      else             a = 32'($urandom_range(0, 15));
      a = a | ($urandom & 32'hFFFE0000);
      do_req(1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)),
             a, $urandom, rd, er, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
